energy_flux_detector: RTL and testbench

ENERGY_FLUX_DETECTOR -- requirements
Module: energy_flux_detector

---
 rtl/beat_pkg.sv | 18 +
 rtl/energy_flux_detector_if.sv | 28 ++
 rtl/flux_history.sv | 41 ++++
 rtl/energy_flux_detector.sv | 130 +++++++++++++
 tb/tb_energy_flux_detector.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/beat_pkg.sv
// Shared definitions for the onset-detection block: post-processing FSM
// states and the default parameter set.
package beat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUX   = 2'd1,
        ST_DECIDE = 2'd2
    } state_e;

    localparam int DEF_W          = 16;
    localparam int DEF_FRAME_LOG2 = 8;
    localparam int DEF_HIST_LOG2  = 3;
    localparam int DEF_TH_SHIFT   = 2;
    localparam int DEF_MIN_FLUX   = 16;
    localparam int DEF_REFRACT    = 4;

endpackage

// File: rtl/energy_flux_detector_if.sv
// Sample stream in, flux/beat results out.
// Handshake: sample_in is consumed on every rising clk edge where
// sample_valid is high (no backpressure, the detector always accepts).
// flux_valid is a one-cycle pulse marking a new flux_out. beat_valid can
// only be high in the same cycle as flux_valid. dbg_state mirrors the
// post-processing FSM.
interface energy_flux_detector_if
    import beat_pkg::*;
#(
    parameter int W = DEF_W
);
    logic signed [W-1:0] sample_in;
    logic                sample_valid;
    logic [W-1:0]        flux_out;
    logic                flux_valid;
    logic                beat_valid;
    state_e              dbg_state;

    modport master (
        output sample_in, sample_valid,
        input  flux_out, flux_valid, beat_valid, dbg_state
    );

    modport slave (
        input  sample_in, sample_valid,
        output flux_out, flux_valid, beat_valid, dbg_state
    );
endinterface

// File: rtl/flux_history.sv
// Circular store of the most recent 2^HIST_LOG2 flux values with a running
// sum and a flag that rises once every slot holds a real value.
module flux_history
    import beat_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int HIST_LOG2 = DEF_HIST_LOG2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [W-1:0]           din,
    output logic [W+HIST_LOG2-1:0] sum,
    output logic                   full
);
    localparam int DEPTH = 1 << HIST_LOG2;
    localparam int SW    = W + HIST_LOG2;

    logic [W-1:0]         mem [DEPTH];
    logic [HIST_LOG2-1:0] wr_ptr;
    logic [HIST_LOG2:0]   fill;

    // Fill count saturates at DEPTH, so its top bit is the full flag.
    assign full = fill[HIST_LOG2];

    // Overwrite the oldest entry and keep the sum in step with the contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            sum    <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + HIST_LOG2'(1);
            if (!full) fill <= fill + (HIST_LOG2 + 1)'(1);
            // Slots not yet written are zero, so this holds while filling.
            sum <= sum - SW'(mem[wr_ptr]) + SW'(din);
        end
    end
endmodule

// File: rtl/energy_flux_detector.sv
// Frame energy accumulator followed by a three-state post-processor that
// turns the rise in frame energy into an onset flux and an adaptive-threshold
// beat decision with a refractory hold-off.
module energy_flux_detector
    import beat_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int FRAME_LOG2 = DEF_FRAME_LOG2,
    parameter int HIST_LOG2  = DEF_HIST_LOG2,
    parameter int TH_SHIFT   = DEF_TH_SHIFT,
    parameter int MIN_FLUX   = DEF_MIN_FLUX,
    parameter int REFRACT    = DEF_REFRACT
) (
    input logic                    clk,
    input logic                    reset,
    energy_flux_detector_if.slave  bus
);
    localparam int AW = W + FRAME_LOG2;
    localparam int SW = W + HIST_LOG2;
    localparam int RW = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);

    // A frame must outlast the FLUX/DECIDE sequence so completions never overlap it.
    generate
        if (FRAME_LOG2 < 2) begin : g_frame_too_short
            $error("energy_flux_detector: FRAME_LOG2 must be at least 2");
        end
    endgenerate

    logic [W-1:0]          abs_s;
    logic [AW-1:0]         acc, acc_sum;
    logic [FRAME_LOG2-1:0] cnt;
    logic                  frame_done;
    logic [W-1:0]          energy, e_prev, flux_q, flux_out_q;
    logic                  flux_valid_q, beat_valid_q, beat;
    logic [RW-1:0]         refr;
    logic [SW-1:0]         hist_sum, mean_w, thr_w;
    logic                  hist_full;
    state_e                state_q, state_d;

    // Magnitude as unsigned; the most negative sample maps to 2^(W-1).
    assign abs_s      = bus.sample_in[W-1] ? (W'(~bus.sample_in) + W'(1)) : W'(bus.sample_in);
    assign acc_sum    = acc + AW'(abs_s);
    assign frame_done = bus.sample_valid && (cnt == '1);

    // Accumulate every accepted sample; latch the frame mean on the last one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            cnt    <= '0;
            energy <= '0;
        end else if (bus.sample_valid) begin
            cnt <= cnt + FRAME_LOG2'(1);
            if (frame_done) begin
                acc    <= '0;
                energy <= acc_sum[AW-1 -: W];
            end else begin
                acc <= acc_sum;
            end
        end
    end

    // Post-processing state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: one cycle each in FLUX and DECIDE after a frame completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (frame_done) state_d = ST_FLUX;
            ST_FLUX:   state_d = ST_DECIDE;
            ST_DECIDE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Threshold from the history before this frame is added; the wider
    // arithmetic cannot overflow and compares the same as a W+1-bit one.
    always_comb begin
        mean_w = hist_sum >> HIST_LOG2;
        thr_w  = mean_w + (mean_w >> TH_SHIFT);
        beat   = hist_full && (SW'(flux_q) > thr_w) &&
                 (flux_q >= W'(MIN_FLUX)) && (refr == '0);
    end

    // Flux from the energy rise, then publish the result and run the hold-off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_prev       <= '0;
            flux_q       <= '0;
            flux_out_q   <= '0;
            flux_valid_q <= 1'b0;
            beat_valid_q <= 1'b0;
            refr         <= '0;
        end else begin
            flux_valid_q <= 1'b0;
            beat_valid_q <= 1'b0;
            if (state_q == ST_FLUX) begin
                flux_q <= (energy > e_prev) ? (energy - e_prev) : '0;
                e_prev <= energy;
            end
            if (state_q == ST_DECIDE) begin
                flux_out_q   <= flux_q;
                flux_valid_q <= 1'b1;
                beat_valid_q <= beat;
                if (beat)              refr <= RW'(REFRACT);
                else if (refr != '0)   refr <= refr - RW'(1);
            end
        end
    end

    flux_history #(
        .W         (W),
        .HIST_LOG2 (HIST_LOG2)
    ) u_history (
        .clk   (clk),
        .reset (reset),
        .wr_en (state_q == ST_DECIDE),
        .din   (flux_q),
        .sum   (hist_sum),
        .full  (hist_full)
    );

    assign bus.flux_out   = flux_out_q;
    assign bus.flux_valid = flux_valid_q;
    assign bus.beat_valid = beat_valid_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_energy_flux_detector.sv
// Directed bench for energy_flux_detector with W=16, 8-sample frames,
// 4-deep history, TH_SHIFT=1, MIN_FLUX=4, REFRACT=2.
module tb_energy_flux_detector;
  import beat_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  energy_flux_detector_if #(.W(W)) bus ();

  energy_flux_detector #(
    .W(W), .FRAME_LOG2(3), .HIST_LOG2(2), .TH_SHIFT(1), .MIN_FLUX(4), .REFRACT(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: expected flux / beat per completed frame, in order
  logic [W-1:0] exp_q[$];
  logic         exp_beat_q[$];

  int           samp_cnt = 0;
  logic         pend = 1'b0;
  int           age = 0;
  logic [W-1:0] cur_flux;
  logic         cur_beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, DUT samples at posedge, check at next negedge.
  task automatic step(input logic v, input logic [W-1:0] s);
    bus.sample_valid = v;
    bus.sample_in    = s;
    @(negedge clk);
    if (pend) begin
      age++;
      if (age == 1) begin
        chk("fv_too_early", 32'(bus.flux_valid), 0);
      end else if (age == 2) begin
        chk("fv_latency", 32'(bus.flux_valid), 1);
        chk("flux_out", 32'(bus.flux_out), 32'(cur_flux));
        chk("beat_valid", 32'(bus.beat_valid), 32'(cur_beat));
      end else begin
        chk("fv_pulse_width", 32'(bus.flux_valid), 0);
        chk("bv_pulse_width", 32'(bus.beat_valid), 0);
        pend = 1'b0;
      end
    end else begin
      chk("quiet_fv", 32'(bus.flux_valid), 0);
      chk("quiet_bv", 32'(bus.beat_valid), 0);
    end
    if (v) begin
      samp_cnt++;
      if (samp_cnt == 8) begin
        samp_cnt = 0;
        pend     = 1'b1;
        age      = 0;
        cur_flux = exp_q.pop_front();
        cur_beat = exp_beat_q.pop_front();
      end
    end
  endtask

  // Eight consecutive samples alternating a, b, a, b ...
  task automatic frame(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_flux, input logic exp_beat);
    exp_q.push_back(exp_flux);
    exp_beat_q.push_back(exp_beat);
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0) ? a : b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  // Asynchronous reset pulse; outputs must clear without waiting for a clock.
  task automatic do_reset();
    bus.sample_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_flux_out", 32'(bus.flux_out), 0);
    chk("rst_flux_valid", 32'(bus.flux_valid), 0);
    chk("rst_beat_valid", 32'(bus.beat_valid), 0);
    chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset    = 1'b1;
    samp_cnt = 0;
    pend     = 1'b0;
    age      = 0;
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;

    // reset held with random traffic: outputs stay zero
    for (int i = 0; i < 20; i++) begin
      bus.sample_valid = 1'($urandom_range(0, 1));
      bus.sample_in    = W'($urandom_range(0, 65535));
      @(negedge clk);
      chk("hold_flux_out", 32'(bus.flux_out), 0);
      chk("hold_flux_valid", 32'(bus.flux_valid), 0);
      chk("hold_beat_valid", 32'(bus.beat_valid), 0);
    end
    bus.sample_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // back-to-back constant 100: flux 100 then 0, never a beat
    frame(16'd100, 16'd100, 16'd100, 1'b0);
    for (int f = 0; f < 5; f++) frame(16'd100, 16'd100, 16'd0, 1'b0);
    idle(4);

    // four silent frames fill history, then +/-200 is an onset
    do_reset();
    for (int f = 0; f < 4; f++) frame(16'd0, 16'd0, 16'd0, 1'b0);
    frame(16'd200, -16'sd200, 16'd200, 1'b1);
    // drop, refractory-suppressed rise, then a rise above mean 150 + 75
    frame(16'd0, 16'd0, 16'd0, 1'b0);
    frame(16'd400, 16'd400, 16'd400, 1'b0);
    frame(16'd800, 16'd800, 16'd400, 1'b0 | 1'b1);
    idle(4);

    // most negative sample after silence: magnitude 32768 without wrap
    do_reset();
    frame(16'd0, 16'd0, 16'd0, 1'b0);
    frame(16'h8000, 16'h8000, 16'h8000, 1'b0);
    idle(4);

    // reset mid-frame discards the five partial samples
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 16'd50);
    do_reset();
    frame(16'd50, 16'd50, 16'd50, 1'b0);
    idle(12);

    chk("exp_q_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
